// File: rtl/memory_arbiter_rr.sv
// -----------------------------------------------------------------------------
// memory_arbiter_rr
//
// Shares one synchronous RAM port between PERIPHERALS requesters: a device
// controller plus a number of LED row controllers. Each requester has its
// own request FIFO. Every cycle an arbiter picks one non-empty FIFO, pops
// its head entry and drives it onto the registered RAM port. Reads carry a
// tag {valid, port} through a MEM_READ_LATENCY-deep pipeline. The tag lets
// the returning mem_rdata go back to the port that asked for it.
//
// Timing of a read with no contention:
//   edge T   : request pushed (data_in_ready high in cycle T-1)
//   cycle T  : grant, head popped
//   cycle T+1: mem_en/mem_addr on the RAM port
//   cycle T+1+MEM_READ_LATENCY : mem_rdata valid from the RAM
//   cycle T+2+MEM_READ_LATENCY : data_out / data_out_ready pulse
//
// Parameters:
//   ADDRESS_WIDTH           word address width
//   DATA_WIDTH              data word width
//   PERIPHERALS             number of requesters (>= 1)
//   PERIPHERALS_FIFO_DEPTH  entries per request FIFO (power of 2, >= 2)
//   MEM_READ_LATENCY        cycles from mem_en to valid mem_rdata (>= 1)
//   ARB_MODE                0 = fixed priority (port 0 highest), 1 = round-robin
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   address         per-port request address, port i in slice i
//   wr              per-port 1 = write, 0 = read
//   data_in         per-port write data, port i in slice i
//   data_in_ready   per-port request strobe (one request per high cycle)
//   fifo_full       per-port FIFO full flag, registered
//   overflow        per-port sticky flag: a request hit a full FIFO
//   data_out        read data returned to the requesters (shared)
//   data_out_ready  one-hot, one-cycle pulse naming the owner of data_out
//   mem_addr        RAM address
//   mem_wdata       RAM write data
//   mem_en          RAM access strobe
//   mem_we          RAM write enable, qualified by mem_en
//   mem_rdata       RAM read data
// -----------------------------------------------------------------------------
module memory_arbiter_rr #(
    parameter int ADDRESS_WIDTH          = 14,
    parameter int DATA_WIDTH             = 16,
    parameter int PERIPHERALS            = 2,
    parameter int PERIPHERALS_FIFO_DEPTH = 16,
    parameter int MEM_READ_LATENCY       = 1,
    parameter int ARB_MODE               = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ADDRESS_WIDTH*PERIPHERALS-1:0]  address,
    input  logic [PERIPHERALS-1:0]                wr,
    input  logic [DATA_WIDTH*PERIPHERALS-1:0]     data_in,
    input  logic [PERIPHERALS-1:0]                data_in_ready,
    output logic [PERIPHERALS-1:0]                fifo_full,
    output logic [PERIPHERALS-1:0]                overflow,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic [PERIPHERALS-1:0]                data_out_ready,
    output logic [ADDRESS_WIDTH-1:0]              mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    output logic                                  mem_en,
    output logic                                  mem_we,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

    localparam int DEPTH   = PERIPHERALS_FIFO_DEPTH;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int IDX_W   = (PERIPHERALS > 1) ? $clog2(PERIPHERALS) : 1;
    localparam int ENTRY_W = ADDRESS_WIDTH + 1 + DATA_WIDTH;
    localparam int LAT     = MEM_READ_LATENCY;

    // -------------------------------------------------------------------------
    // Request FIFO state, one set per port
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0]     fifoMem_q [PERIPHERALS][DEPTH];
    logic [PTR_W-1:0]       wrPtr_q   [PERIPHERALS];
    logic [PTR_W-1:0]       rdPtr_q   [PERIPHERALS];
    logic [CNT_W-1:0]       count_q   [PERIPHERALS];
    logic [CNT_W-1:0]       count_d   [PERIPHERALS];
    logic [PERIPHERALS-1:0] full_q;
    logic [PERIPHERALS-1:0] overflow_q;

    logic [PERIPHERALS-1:0] pushReq;
    logic [PERIPHERALS-1:0] popReq;
    logic [PERIPHERALS-1:0] nonEmpty;

    // -------------------------------------------------------------------------
    // Arbiter state and the popped head entry
    // -------------------------------------------------------------------------
    logic                   grantValid;
    logic [IDX_W-1:0]       grantIdx;
    logic [IDX_W-1:0]       lastGrant_q;
    int                     rrStart;
    int                     rrDist;
    int                     rrBest;

    logic [ENTRY_W-1:0]     headEntry;
    logic [ADDRESS_WIDTH-1:0] headAddr;
    logic                   headWr;
    logic [DATA_WIDTH-1:0]  headData;

    // -------------------------------------------------------------------------
    // RAM port registers and read-tag pipeline
    // -------------------------------------------------------------------------
    logic                     memEn_q;
    logic                     memWe_q;
    logic [ADDRESS_WIDTH-1:0] memAddr_q;
    logic [DATA_WIDTH-1:0]    memWdata_q;
    logic [IDX_W-1:0]         issuePort_q;

    logic                     tagValid_q [LAT];
    logic [IDX_W-1:0]         tagPort_q  [LAT];

    logic [DATA_WIDTH-1:0]    dataOut_q;
    logic [PERIPHERALS-1:0]   dataOutReady_q;
    logic [PERIPHERALS-1:0]   dataOutReady_d;

    // A strobe against a full FIFO is dropped. full_q is the registered
    // flag, so a pop in the same cycle does not rescue the request.
    always_comb begin
        pushReq  = '0;
        nonEmpty = '0;
        for (int i = 0; i < PERIPHERALS; i++) begin
            pushReq[i]  = data_in_ready[i] && !full_q[i];
            nonEmpty[i] = (count_q[i] != '0);
        end
    end

    // Both modes share one search. The winner is the non-empty port closest
    // to the start index, walking upward with wrap-around. Fixed priority
    // always starts at port 0. Round-robin starts one past the last grant.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        rrStart    = 0;
        rrDist     = 0;
        rrBest     = PERIPHERALS;
        if (ARB_MODE != 0) begin
            rrStart = int'(lastGrant_q) + 1;
            if (rrStart >= PERIPHERALS) begin
                rrStart = 0;
            end
        end
        for (int i = 0; i < PERIPHERALS; i++) begin
            rrDist = i - rrStart;
            if (rrDist < 0) begin
                rrDist = rrDist + PERIPHERALS;
            end
            if (nonEmpty[i] && (rrDist < rrBest)) begin
                grantValid = 1'b1;
                grantIdx   = IDX_W'(i);
                rrBest     = rrDist;
            end
        end
    end

    // The granted port pops its head entry this cycle.
    always_comb begin
        popReq = '0;
        for (int i = 0; i < PERIPHERALS; i++) begin
            popReq[i] = grantValid && (grantIdx == IDX_W'(i));
        end
    end

    assign headEntry = fifoMem_q[grantIdx][rdPtr_q[grantIdx]];
    assign headAddr  = headEntry[ENTRY_W-1 -: ADDRESS_WIDTH];
    assign headWr    = headEntry[DATA_WIDTH];
    assign headData  = headEntry[DATA_WIDTH-1:0];

    // Next occupancy. A push and a pop in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < PERIPHERALS; i++) begin
            count_d[i] = count_q[i];
            case ({pushReq[i], popReq[i]})
                2'b10:   count_d[i] = count_q[i] + 1'b1;
                2'b01:   count_d[i] = count_q[i] - 1'b1;
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // FIFO storage is not reset. Pointers and counts decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PERIPHERALS; i++) begin
            if (pushReq[i]) begin
                fifoMem_q[i][wrPtr_q[i]] <= {address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                                             wr[i],
                                             data_in[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Pointer, count, full and overflow bookkeeping. The pointers are
    // exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PERIPHERALS; i++) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
                count_q[i] <= '0;
            end
            full_q     <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < PERIPHERALS; i++) begin
                if (pushReq[i]) begin
                    wrPtr_q[i] <= wrPtr_q[i] + 1'b1;
                end
                if (popReq[i]) begin
                    rdPtr_q[i] <= rdPtr_q[i] + 1'b1;
                end
                count_q[i] <= count_d[i];
                full_q[i]  <= (count_d[i] == CNT_W'(DEPTH));
                if (data_in_ready[i] && full_q[i]) begin
                    overflow_q[i] <= 1'b1;
                end
            end
        end
    end

    // RAM port. The address and write data hold on idle cycles, so only
    // mem_en and mem_we drop. The round-robin pointer moves only on a grant.
    // It resets to the last port so that port 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            memEn_q     <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            issuePort_q <= '0;
            lastGrant_q <= IDX_W'(PERIPHERALS - 1);
        end else if (grantValid) begin
            memEn_q     <= 1'b1;
            memWe_q     <= headWr;
            memAddr_q   <= headAddr;
            memWdata_q  <= headData;
            issuePort_q <= grantIdx;
            lastGrant_q <= grantIdx;
        end else begin
            memEn_q     <= 1'b0;
            memWe_q     <= 1'b0;
        end
    end

    // The tag enters in the same cycle the read is on the RAM port. It then
    // reaches the last stage in the cycle mem_rdata becomes valid. Writes
    // push an invalid tag, so the pipeline keeps a fixed cadence.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) begin
                tagValid_q[k] <= 1'b0;
                tagPort_q[k]  <= '0;
            end
        end else begin
            tagValid_q[0] <= memEn_q && !memWe_q;
            tagPort_q[0]  <= issuePort_q;
            for (int k = 1; k < LAT; k++) begin
                tagValid_q[k] <= tagValid_q[k-1];
                tagPort_q[k]  <= tagPort_q[k-1];
            end
        end
    end

    // One-hot owner of the read data that is arriving now.
    always_comb begin
        dataOutReady_d = '0;
        for (int i = 0; i < PERIPHERALS; i++) begin
            dataOutReady_d[i] = tagValid_q[LAT-1] && (tagPort_q[LAT-1] == IDX_W'(i));
        end
    end

    // Return stage: capture mem_rdata and pulse the owner's ready for one
    // cycle. data_out holds between returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut_q      <= '0;
            dataOutReady_q <= '0;
        end else begin
            dataOutReady_q <= dataOutReady_d;
            if (tagValid_q[LAT-1]) begin
                dataOut_q <= mem_rdata;
            end
        end
    end

    assign fifo_full      = full_q;
    assign overflow       = overflow_q;
    assign data_out       = dataOut_q;
    assign data_out_ready = dataOutReady_q;
    assign mem_addr       = memAddr_q;
    assign mem_wdata      = memWdata_q;
    assign mem_en         = memEn_q;
    assign mem_we         = memWe_q;

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter_rr
//
// Directed bench for memory_arbiter_rr. Four instances share one clock and
// one reset:
//   dutA  P=2, L=1, round-robin    write/read-back through a small RAM model
//   dutB  P=4, L=1, round-robin    grant rotation under full load
//   dutC  P=4, L=1, fixed priority starvation, FIFO full and overflow
//   dutD  P=2, L=3, round-robin    back-to-back tagged reads, reset mid-flight
// -----------------------------------------------------------------------------
module tb_memory_arbiter_rr;

    logic clk;
    logic reset;

    int errorCount;
    int checkCount;

    // ---------------- dutA ----------------
    logic [27:0] aAddress;
    logic [1:0]  aWr;
    logic [31:0] aDataIn;
    logic [1:0]  aReady;
    logic [1:0]  aFull, aOvf, aDor;
    logic [15:0] aDataOut, aMemWdata, aMemRdata;
    logic [13:0] aMemAddr;
    logic        aMemEn, aMemWe;
    logic [15:0] aRam [256];

    // ---------------- dutB ----------------
    logic [55:0] bAddress;
    logic [3:0]  bWr, bReady, bFull, bOvf, bDor;
    logic [63:0] bDataIn;
    logic [15:0] bDataOut, bMemWdata, bMemRdata;
    logic [13:0] bMemAddr;
    logic        bMemEn, bMemWe;

    // ---------------- dutC ----------------
    logic [55:0] cAddress;
    logic [3:0]  cWr, cReady, cFull, cOvf, cDor;
    logic [63:0] cDataIn;
    logic [15:0] cDataOut, cMemWdata, cMemRdata;
    logic [13:0] cMemAddr;
    logic        cMemEn, cMemWe;

    // ---------------- dutD ----------------
    logic [27:0] dAddress;
    logic [1:0]  dWr, dReady, dFull, dOvf, dDor;
    logic [31:0] dDataIn;
    logic [15:0] dDataOut, dMemWdata, dMemRdata;
    logic [13:0] dMemAddr;
    logic        dMemEn, dMemWe;
    logic [15:0] dPipe0, dPipe1;

    memory_arbiter_rr #(.PERIPHERALS(2), .MEM_READ_LATENCY(1), .ARB_MODE(1)) dutA (
        .clk(clk), .reset(reset), .address(aAddress), .wr(aWr), .data_in(aDataIn),
        .data_in_ready(aReady), .fifo_full(aFull), .overflow(aOvf), .data_out(aDataOut),
        .data_out_ready(aDor), .mem_addr(aMemAddr), .mem_wdata(aMemWdata),
        .mem_en(aMemEn), .mem_we(aMemWe), .mem_rdata(aMemRdata));

    memory_arbiter_rr #(.PERIPHERALS(4), .MEM_READ_LATENCY(1), .ARB_MODE(1)) dutB (
        .clk(clk), .reset(reset), .address(bAddress), .wr(bWr), .data_in(bDataIn),
        .data_in_ready(bReady), .fifo_full(bFull), .overflow(bOvf), .data_out(bDataOut),
        .data_out_ready(bDor), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
        .mem_en(bMemEn), .mem_we(bMemWe), .mem_rdata(bMemRdata));

    memory_arbiter_rr #(.PERIPHERALS(4), .MEM_READ_LATENCY(1), .ARB_MODE(0)) dutC (
        .clk(clk), .reset(reset), .address(cAddress), .wr(cWr), .data_in(cDataIn),
        .data_in_ready(cReady), .fifo_full(cFull), .overflow(cOvf), .data_out(cDataOut),
        .data_out_ready(cDor), .mem_addr(cMemAddr), .mem_wdata(cMemWdata),
        .mem_en(cMemEn), .mem_we(cMemWe), .mem_rdata(cMemRdata));

    memory_arbiter_rr #(.PERIPHERALS(2), .MEM_READ_LATENCY(3), .ARB_MODE(1)) dutD (
        .clk(clk), .reset(reset), .address(dAddress), .wr(dWr), .data_in(dDataIn),
        .data_in_ready(dReady), .fifo_full(dFull), .overflow(dOvf), .data_out(dDataOut),
        .data_out_ready(dDor), .mem_addr(dMemAddr), .mem_wdata(dMemWdata),
        .mem_en(dMemEn), .mem_we(dMemWe), .mem_rdata(dMemRdata));

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle-latency RAM for dutA. A write is visible to a read
    // issued in a later cycle.
    always @(posedge clk) begin
        if (aMemEn && aMemWe) begin
            aRam[aMemAddr[7:0]] <= aMemWdata;
        end
        if (aMemEn && !aMemWe) begin
            aMemRdata <= aRam[aMemAddr[7:0]];
        end
    end

    // Three-cycle-latency ROM for dutD. The data is address ^ 16'h5A5A.
    always @(posedge clk) begin
        dPipe0    <= {2'b00, dMemAddr} ^ 16'h5A5A;
        dPipe1    <= dPipe0;
        dMemRdata <= dPipe1;
    end

    // Advance one clock and settle just past the edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Count a comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Put every instance's request inputs into a quiet state.
    task automatic applyStimulus();
        aAddress = '0; aWr = '0; aDataIn = '0; aReady = '0;
        bAddress = '0; bWr = '0; bDataIn = '0; bReady = '0; bMemRdata = '0;
        cAddress = '0; cWr = '0; cDataIn = '0; cReady = '0; cMemRdata = '0;
        dAddress = '0; dWr = '0; dDataIn = '0; dReady = '0;
    endtask

    initial begin
        int grantsPerPort [4];
        int gIdx;
        errorCount = 0;
        checkCount = 0;
        aMemRdata  = '0;
        applyStimulus();

        // ---------------- reset ----------------
        reset = 1'b1;
        stepClock();
        stepClock();
        checkOutput("rst_mem_en",   64'(aMemEn),   64'h0);
        checkOutput("rst_mem_addr", 64'(aMemAddr), 64'h0);
        checkOutput("rst_dor",      64'(aDor),     64'h0);
        checkOutput("rst_full",     64'(aFull),    64'h0);
        checkOutput("rst_ovf",      64'(aOvf),     64'h0);
        reset = 1'b0;
        stepClock();

        // ---------------- A: port 1 writes BEEF to 0x10, then reads it back ----------------
        aAddress = {14'h0010, 14'h0000}; aWr = 2'b10; aDataIn = {16'hBEEF, 16'h0000}; aReady = 2'b10;
        stepClock();                                    // E1 push write
        aWr = 2'b00; aReady = 2'b10;
        stepClock();                                    // E2 push read, write on RAM port
        aReady = 2'b00;
        checkOutput("A_wr_en",    64'(aMemEn),    64'h1);
        checkOutput("A_wr_we",    64'(aMemWe),    64'h1);
        checkOutput("A_wr_addr",  64'(aMemAddr),  64'h0010);
        checkOutput("A_wr_wdata", 64'(aMemWdata), 64'hBEEF);
        stepClock();                                    // E3 read on RAM port
        checkOutput("A_rd_en",    64'(aMemEn),    64'h1);
        checkOutput("A_rd_we",    64'(aMemWe),    64'h0);
        checkOutput("A_rd_addr",  64'(aMemAddr),  64'h0010);
        stepClock();                                    // E4 rdata valid
        checkOutput("A_dor_early", 64'(aDor), 64'h0);
        stepClock();                                    // E5 return
        checkOutput("A_dor",      64'(aDor),     64'h2);
        checkOutput("A_data_out", 64'(aDataOut), 64'hBEEF);
        stepClock();
        checkOutput("A_dor_pulse", 64'(aDor),     64'h0);
        checkOutput("A_data_hold", 64'(aDataOut), 64'hBEEF);

        // ---------------- B: round-robin rotation with four ports loaded ----------------
        for (int p = 0; p < 4; p++) grantsPerPort[p] = 0;
        bWr = 4'hF;
        for (int k = 1; k <= 17; k++) begin
            if (k <= 4) begin
                for (int i = 0; i < 4; i++) bAddress[i*14 +: 14] = 14'((i << 8) | (k - 1));
                bReady = 4'hF;
            end else begin
                bReady = 4'h0;
            end
            stepClock();
            if (k >= 2) begin
                gIdx = k - 2;
                checkOutput($sformatf("B_en_%0d", gIdx),   64'(bMemEn),   64'h1);
                checkOutput($sformatf("B_addr_%0d", gIdx), 64'(bMemAddr),
                            64'(((gIdx % 4) << 8) | (gIdx / 4)));
                if (bMemEn) grantsPerPort[bMemAddr[9:8]]++;
            end
        end
        stepClock();
        checkOutput("B_idle_en", 64'(bMemEn), 64'h0);
        for (int p = 0; p < 4; p++) begin
            checkOutput($sformatf("B_grants_p%0d", p), 64'(grantsPerPort[p]), 64'd4);
        end

        // ---------------- C: fixed priority, starvation and overflow ----------------
        cWr = 4'hF;
        for (int k = 1; k <= 17; k++) begin
            for (int i = 0; i < 4; i++) cAddress[i*14 +: 14] = 14'((i << 8) | (k - 1));
            cReady = 4'hF;
            stepClock();
            if (k >= 2) begin
                checkOutput($sformatf("C_p0_addr_%0d", k), 64'(cMemAddr), 64'(k - 2));
            end
            if (k == 15) checkOutput("C_full_15", 64'(cFull), 64'h0);
            if (k == 16) begin
                checkOutput("C_full_16", 64'(cFull), 64'hE);
                checkOutput("C_ovf_16",  64'(cOvf),  64'h0);
            end
            if (k == 17) begin
                checkOutput("C_full_17", 64'(cFull), 64'hE);
                checkOutput("C_ovf_17",  64'(cOvf),  64'hE);
            end
        end
        cReady = 4'h0;
        stepClock();                                    // E18 last port-0 entry
        checkOutput("C_p0_last", 64'(cMemAddr), 64'h0010);
        stepClock();                                    // E19 port 1 finally served
        checkOutput("C_p1_first_en", 64'(cMemEn),   64'h1);
        checkOutput("C_p1_first",    64'(cMemAddr), 64'h0100);
        checkOutput("C_full_19",     64'(cFull),    64'hC);
        for (int k = 20; k <= 35; k++) begin
            stepClock();
            checkOutput($sformatf("C_drain_%0d", k), 64'(cMemAddr),
                        (k <= 34) ? 64'(16'h0100 + (k - 19)) : 64'h0200);
        end
        checkOutput("C_ovf_sticky", 64'(cOvf), 64'hE);

        // ---------------- D: L=3, ports 0 and 1 read back to back ----------------
        dAddress = {14'h0032, 14'h0021}; dWr = 2'b00; dReady = 2'b11;
        stepClock();                                    // E1
        dReady = 2'b00;
        for (int e = 2; e <= 5; e++) stepClock();
        checkOutput("D_dor_early", 64'(dDor), 64'h0);
        stepClock();                                    // E6
        checkOutput("D_dor_p0",  64'(dDor),     64'h1);
        checkOutput("D_data_p0", 64'(dDataOut), 64'h5A7B);
        stepClock();                                    // E7
        checkOutput("D_dor_p1",  64'(dDor),     64'h2);
        checkOutput("D_data_p1", 64'(dDataOut), 64'h5A68);
        stepClock();
        checkOutput("D_dor_done", 64'(dDor), 64'h0);

        // ---------------- reset with reads in flight and requests queued ----------------
        for (int j = 0; j < 6; j++) begin
            dAddress = {14'(16'h0080 + j), 14'(16'h0040 + j)};
            dReady = 2'b11;
            stepClock();
        end
        dReady = 2'b00;
        reset = 1'b1;
        stepClock();
        reset = 1'b0;
        checkOutput("R_mem_en",    64'(dMemEn),    64'h0);
        checkOutput("R_mem_we",    64'(dMemWe),    64'h0);
        checkOutput("R_mem_addr",  64'(dMemAddr),  64'h0);
        checkOutput("R_mem_wdata", 64'(dMemWdata), 64'h0);
        checkOutput("R_data_out",  64'(dDataOut),  64'h0);
        checkOutput("R_dor",       64'(dDor),      64'h0);
        checkOutput("R_full",      64'(dFull),     64'h0);
        checkOutput("R_c_ovf",     64'(cOvf),      64'h0);
        checkOutput("R_c_full",    64'(cFull),     64'h0);
        for (int k = 0; k < 8; k++) begin
            stepClock();
            checkOutput($sformatf("R_after_dor_%0d", k), 64'(dDor),   64'h0);
            checkOutput($sformatf("R_after_en_%0d", k),  64'(dMemEn), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
